// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
//
// Streams a finished SIZE x SIZE result matrix out of the systolic array.
// A start handshake launches a sweep of the array's row/column selects over
// every element. Each sampled value is presented on a val/rdy stream at one
// element per cycle. The stream holds while the consumer applies backpressure.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start_val  : request to drain the current matrix
//   start_rdy  : drain can be accepted (IDLE and not in reset)
//   col_major  : order select, sampled on start handshake (1 = row fastest)
//   out_rsel   : row select to the array
//   out_csel   : column select to the array
//   b_s_out    : array result at (out_rsel, out_csel), combinational on selects
//   send_msg   : result element
//   send_last  : marks the final element of the matrix
//   send_val   : send_msg valid
//   send_rdy   : consumer accepts
//   done       : one-cycle pulse after the final element is accepted
// -----------------------------------------------------------------------------
module systolic_result_drain #(
    parameter int SIZE  = 16,
    parameter int NBITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_val,
    output logic                    start_rdy,
    input  logic                    col_major,
    output logic [$clog2(SIZE)-1:0] out_rsel,
    output logic [$clog2(SIZE)-1:0] out_csel,
    input  logic [NBITS-1:0]        b_s_out,
    output logic [NBITS-1:0]        send_msg,
    output logic                    send_last,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic                    done
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] IDX_MAX  = AW'(SIZE - 1);
    localparam logic [AW-1:0] IDX_ZERO = AW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      rsel_q, rsel_d;
    logic [AW-1:0]      csel_q, csel_d;
    logic               cm_q, cm_d;
    logic [NBITS-1:0]   msg_q, msg_d;
    logic               val_q, val_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               is_last_s;
    logic               load_s;

    // The final element is (SIZE-1, SIZE-1) in both sweep orders.
    assign is_last_s = (rsel_q == IDX_MAX) && (csel_q == IDX_MAX);
    // Output register is free when empty or being consumed this cycle.
    assign load_s    = !val_q || send_rdy;

    // Next-state and datapath decisions.
    always_comb begin
        state_d = state_q;
        rsel_d  = rsel_q;
        csel_d  = csel_q;
        cm_d    = cm_q;
        msg_d   = msg_q;
        val_d   = val_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_val) begin
                    cm_d    = col_major;
                    rsel_d  = IDX_ZERO;
                    csel_d  = IDX_ZERO;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (load_s) begin
                    msg_d  = b_s_out;
                    val_d  = 1'b1;
                    last_d = is_last_s;
                    if (is_last_s) begin
                        // Counters park on the last index so the selects hold.
                        state_d = ST_FLUSH;
                    end else if (cm_q) begin
                        rsel_d = rsel_q + 1'b1;
                        csel_d = (rsel_q == IDX_MAX) ? csel_q + 1'b1 : csel_q;
                    end else begin
                        csel_d = csel_q + 1'b1;
                        rsel_d = (csel_q == IDX_MAX) ? rsel_q + 1'b1 : rsel_q;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (val_q && send_rdy && last_q) begin
                    val_d   = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rsel_q  <= IDX_ZERO;
            csel_q  <= IDX_ZERO;
            cm_q    <= 1'b0;
            msg_q   <= {NBITS{1'b0}};
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rsel_q  <= rsel_d;
            csel_q  <= csel_d;
            cm_q    <= cm_d;
            msg_q   <= msg_d;
            val_q   <= val_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign start_rdy = (state_q == ST_IDLE) && !rst;
    assign out_rsel  = rsel_q;
    assign out_csel  = csel_q;
    assign send_msg  = msg_q;
    assign send_val  = val_q;
    assign send_last = last_q;
    assign done      = done_q;

endmodule
